am2940_counter_core: RTL

Register and counter core of the Am2940 DMA address generator slice. It holds the 3-bit control register, the address register/counter pair and the word register/counter pair, and executes the 3-bit instruction each clock. It generates DONE and the cascade carries, and drives the inputs and select of the downstream data-bus mux (`address_data`, `word_data`, `ctrl_reg_in`, `seld`).

---
 rtl/am2940_pkg.sv | 31 +++
 rtl/am2940_updown_counter.sv | 46 ++++
 rtl/am2940_counter_core.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/am2940_pkg.sv
// ----------------------------------------------------------------------------
// am2940_pkg
// Shared constants for the Am2940 register/counter core:
//   - 3-bit instruction opcodes (WRCR .. ENCNT)
//   - control-register mode encodings (CR[1:0])
//   - select codes driven to the downstream data-bus mux
// ----------------------------------------------------------------------------
package am2940_pkg;

   // Instruction opcodes
   localparam logic [2:0] WRCR   = 3'd0;
   localparam logic [2:0] RDCR   = 3'd1;
   localparam logic [2:0] RDWC   = 3'd2;
   localparam logic [2:0] RDAC   = 3'd3;
   localparam logic [2:0] REINIT = 3'd4;
   localparam logic [2:0] LDADDR = 3'd5;
   localparam logic [2:0] LDWC   = 3'd6;
   localparam logic [2:0] ENCNT  = 3'd7;

   // CR[1:0] transfer modes
   localparam logic [1:0] MODE_WC_DOWN = 2'd0;  // WC counts down, done at WC==1
   localparam logic [1:0] MODE_WC_CMP  = 2'd1;  // WC counts up, done at WC==WR
   localparam logic [1:0] MODE_AC_CMP  = 2'd2;  // WC counts up, done at AC==WR
   localparam logic [1:0] MODE_NONE    = 2'd3;  // WC counts up, never done

   // Data-bus mux select codes
   localparam logic [1:0] SEL_ADDR = 2'b00;
   localparam logic [1:0] SEL_WORD = 2'b01;
   localparam logic [1:0] SEL_CTRL = 2'b10;

endpackage

// File: rtl/am2940_updown_counter.sv
// ----------------------------------------------------------------------------
// am2940_updown_counter
// Loadable WIDTH-bit up/down counter, wraps modulo 2^WIDTH.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears q)
//   load,load_val : synchronous load, takes priority over counting
//   en, down      : count enable and direction (1 = decrement)
//   q             : current count
//   q_next        : value q will take at the next edge
//   tc            : terminal count (q==0 counting down, q==all-ones up)
// ----------------------------------------------------------------------------
module am2940_updown_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             down,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_next,
   output logic             tc
);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      q_next = q;
      if (load)
         q_next = load_val;
      else if (en)
         q_next = down ? q - WIDTH'(1) : q + WIDTH'(1);
   end

   // NOTE: state uses non-blocking assignments; reset is asynchronous so the
   // counter clears even while an ENCNT is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else
         q <= q_next;
   end

   assign tc = down ? (q == '0) : (q == '1);

endmodule

// File: rtl/am2940_counter_core.sv
// ----------------------------------------------------------------------------
// am2940_counter_core
// Register/counter core of the Am2940 DMA address generator slice.
// Holds CR, AR/AC and WR/WC, executes one 3-bit instruction per clock,
// produces DONE and the cascade carries, and drives the data-bus mux.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   instr        : instruction code, sampled every rising edge
//   din          : data bus input for WRCR/LDADDR/LDWC
//   aci, wci     : address / word count enables (carry-in)
//   address_data : AC value         word_data : WC value
//   ctrl_reg_in  : CR value         seld      : mux select (from instr)
//   data_oe      : high for read instructions
//   aco, wco     : address / word carry-borrow out
//   done         : transfer complete
// Build option:
//   AM2940_DONE_REG_EN : register done from next-state values (glitch-free,
//                        same cycle alignment as the combinational version).
// ----------------------------------------------------------------------------
module am2940_counter_core
   import am2940_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       instr,
   input  logic [WIDTH-1:0] din,
   input  logic             aci,
   input  logic             wci,
   output logic [WIDTH-1:0] address_data,
   output logic [WIDTH-1:0] word_data,
   output logic [2:0]       ctrl_reg_in,
   output logic [1:0]       seld,
   output logic             data_oe,
   output logic             aco,
   output logic             wco,
   output logic             done
);

   logic [2:0]       cr, cr_next;
   logic [WIDTH-1:0] ar, ar_next;
   logic [WIDTH-1:0] wr, wr_next;
   logic [WIDTH-1:0] ac, ac_next, wc, wc_next;
   logic             ac_tc, wc_tc;
   logic [WIDTH-1:0] wc_src;
   logic             wc_down;

   wire [1:0] mode = cr[1:0];

   function automatic logic done_of(input logic [1:0]       m,
                                    input logic [WIDTH-1:0] ac_v,
                                    input logic [WIDTH-1:0] wc_v,
                                    input logic [WIDTH-1:0] wr_v);
      case (m)
         MODE_WC_DOWN: done_of = (wc_v == WIDTH'(1));
         MODE_WC_CMP:  done_of = (wc_v == wr_v);
         MODE_AC_CMP:  done_of = (ac_v == wr_v);
         default:      done_of = 1'b0;
      endcase
   endfunction

   // Plain registers: CR, AR, WR
   always_comb begin
      cr_next = cr;
      ar_next = ar;
      wr_next = wr;
      case (instr)
         WRCR:    cr_next = din[2:0];
         LDADDR:  ar_next = din;
         LDWC:    wr_next = din;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cr <= '0;
         ar <= '0;
         wr <= '0;
      end else begin
         cr <= cr_next;
         ar <= ar_next;
         wr <= wr_next;
      end
   end

   // Address counter: LDADDR loads din, REINIT restores AR
   am2940_updown_counter #(.WIDTH(WIDTH)) u_ac (
      .clk      (clk),
      .rst      (rst),
      .load     ((instr == REINIT) || (instr == LDADDR)),
      .load_val ((instr == LDADDR) ? din : ar),
      .en       ((instr == ENCNT) && aci),
      .down     (cr[2]),
      .q        (ac),
      .q_next   (ac_next),
      .tc       (ac_tc)
   );

   // Word counter: only mode 0 loads a count; compare modes start from 0
   assign wc_src  = (instr == LDWC) ? din : wr;
   assign wc_down = (mode == MODE_WC_DOWN);

   am2940_updown_counter #(.WIDTH(WIDTH)) u_wc (
      .clk      (clk),
      .rst      (rst),
      .load     ((instr == REINIT) || (instr == LDWC)),
      .load_val (wc_down ? wc_src : '0),
      .en       ((instr == ENCNT) && wci),
      .down     (wc_down),
      .q        (wc),
      .q_next   (wc_next),
      .tc       (wc_tc)
   );

   // Mux select and read enable follow instr with no latency
   always_comb begin
      case (instr)
         RDCR:    seld = SEL_CTRL;
         RDWC:    seld = SEL_WORD;
         default: seld = SEL_ADDR;
      endcase
   end

   assign data_oe = (instr == RDCR) || (instr == RDWC) || (instr == RDAC);

   assign aco = aci & ac_tc;
   assign wco = wci & wc_tc;

   assign address_data = ac;
   assign word_data    = wc;
   assign ctrl_reg_in  = cr;

`ifdef AM2940_DONE_REG_EN
   // Loaded from next-state values so it lines up with the counter outputs.
   logic done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         done_q <= 1'b0;
      else
         done_q <= done_of(cr_next[1:0], ac_next, wc_next, wr_next);
   end

   assign done = done_q;
`else
   assign done = done_of(mode, ac, wc, wr);
`endif

endmodule
